// File: rtl/mem_unit_if.sv
// Request/response bundle for mem_unit: read/write/clear requests in,
// registered read data and status out.
interface mem_unit_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic                      read_en;
    logic                      write_en;
    logic [SEL_W-1:0]          src_sel;
    logic [ADDR_W-1:0]         address;
    logic [NUM_SRC*DATA_W-1:0] data_src;
    logic                      clear;
    logic [DATA_W-1:0]         data_out;
    logic                      data_valid;
    logic                      ready;
    logic                      sel_err;

    modport master (
        output read_en, write_en, src_sel, address, data_src, clear,
        input  data_out, data_valid, ready, sel_err
    );

    modport slave (
        input  read_en, write_en, src_sel, address, data_src, clear,
        output data_out, data_valid, ready, sel_err
    );
endinterface

// File: rtl/mem_unit.sv
// Single-port word memory with multi-source write mux, write-first read
// bypass and a zeroing sweep after reset or clear.
module mem_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic      clk,
    input  logic      rst,
    mem_unit_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, IDLE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                sel_err_q, sel_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                sel_ok;
    logic [DATA_W-1:0]   src_word;
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;

    always_comb begin
        sel_ok   = int'(bus.src_sel) < NUM_SRC;
        src_word = '0;
        for (int k = 0; k < NUM_SRC; k++)
            if (int'(bus.src_sel) == k) src_word = bus.data_src[k*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sel_err_d    = sel_err_q;
        we           = 1'b0;
        waddr        = bus.address;
        wdata        = src_word;
        case (state_q)
            INIT: begin
                // Requests are ignored here; the port belongs to the sweep.
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
                else                             cnt_d   = cnt_q + ADDR_W'(1);
            end
            IDLE: begin
                if (bus.clear) begin
                    state_d   = INIT;
                    cnt_d     = '0;
                    sel_err_d = 1'b0;
                end else begin
                    if (bus.write_en) begin
                        if (sel_ok) we        = 1'b1;
                        else        sel_err_d = 1'b1;
                    end
                    if (bus.read_en) begin
                        // Same-cycle write to the read address is forwarded.
                        data_valid_d = 1'b1;
                        data_out_d   = we ? src_word : mem[bus.address];
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.ready      = (state_q == IDLE);
    assign bus.sel_err    = sel_err_q;
endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: directed scenarios plus randomized traffic checked
// against an array-based reference memory.
module tb_mem_unit;
    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int NS    = 2;
    localparam int SW    = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] mdl [DEPTH];
    logic          m_err;
    logic [DW-1:0] m_out;

    mem_unit_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .SEL_W(SW)) bus ();

    mem_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .SEL_W(SW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;
        bus.src_sel  = '0;
        bus.address  = '0;
        bus.data_src = '0;
        bus.clear    = 1'b0;
    endtask

    task automatic drive(input logic re, input logic we, input logic [SW-1:0] sel,
                         input logic [AW-1:0] a, input logic [NS*DW-1:0] src, input logic clr);
        bus.read_en  = re;
        bus.write_en = we;
        bus.src_sel  = sel;
        bus.address  = a;
        bus.data_src = src;
        bus.clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        m_err = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        #7;
        total++; if (bus.ready !== 1'b0)      begin bad++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.data_valid); end
        total++; if (bus.data_out !== '0)     begin bad++; $display("FAIL rst_dout: got %h want 0", bus.data_out); end
        total++; if (bus.sel_err !== 1'b0)    begin bad++; $display("FAIL rst_selerr: got %b want 0", bus.sel_err); end
        @(posedge clk); #1;
        rst = 1'b1;
        begin
            int n = 0;
            do begin @(posedge clk); #1; n++; end while (bus.ready !== 1'b1 && n < 2000);
            total++; if (n != DEPTH) begin bad++; $display("FAIL init_len: got %0d want %0d", n, DEPTH); end
        end
        model_zero();
        m_out = '0;
    endtask

    task automatic test_init_zero();
        logic [AW-1:0] a;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? AW'(0) : (i == 1) ? AW'(DEPTH - 1) : AW'($urandom_range(0, DEPTH - 1));
            drive(1, 0, '0, a, '0, 0);
            total++; if (bus.data_valid !== 1'b1 || bus.data_out !== '0)
                begin bad++; $display("FAIL init_zero[%0d]: got v=%b d=%h want v=1 d=0000", a, bus.data_valid, bus.data_out); end
        end
        m_out = '0;
    endtask

    task automatic test_write_read();
        drive(0, 1, 2'd0, 10'd0, {16'h0007, 16'h0004}, 0);
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL wr_novalid: got %b want 0", bus.data_valid); end
        drive(1, 0, '0, 10'd0, '0, 0);
        total++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'h0004)
            begin bad++; $display("FAIL rd_addr0: got v=%b d=%h want v=1 d=0004", bus.data_valid, bus.data_out); end
        idle(); @(posedge clk); #1;
        total++; if (bus.data_valid !== 1'b0 || bus.data_out !== 16'h0004)
            begin bad++; $display("FAIL rd_hold: got v=%b d=%h want v=0 d=0004", bus.data_valid, bus.data_out); end
        mdl[0] = 16'h0004;
    endtask

    task automatic test_rw_same();
        drive(1, 1, 2'd1, 10'd5, {16'h0007, 16'h1234}, 0);
        total++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'h0007)
            begin bad++; $display("FAIL rw_bypass: got v=%b d=%h want v=1 d=0007", bus.data_valid, bus.data_out); end
        mdl[5] = 16'h0007;
    endtask

    task automatic test_sel_err();
        total++; if (bus.sel_err !== 1'b0) begin bad++; $display("FAIL selerr_pre: got %b want 0", bus.sel_err); end
        drive(0, 1, 2'd2, 10'd3, {16'hAAAA, 16'h5555}, 0);
        total++; if (bus.sel_err !== 1'b1) begin bad++; $display("FAIL selerr_set: got %b want 1", bus.sel_err); end
        drive(1, 0, '0, 10'd3, '0, 0);
        total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL selerr_mem: got %h want 0000", bus.data_out); end
        drive(1, 1, 2'd3, 10'd5, {16'hAAAA, 16'h5555}, 0);
        total++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'h0007 || bus.sel_err !== 1'b1)
            begin bad++; $display("FAIL selerr_rd: got v=%b d=%h e=%b want v=1 d=0007 e=1", bus.data_valid, bus.data_out, bus.sel_err); end
        m_err = 1'b1;
        m_out = 16'h0007;
    endtask

    task automatic test_random();
        logic re, we;
        logic [SW-1:0] sel;
        logic [AW-1:0] a;
        logic [NS*DW-1:0] src;
        logic [DW-1:0] wv;
        logic exp_v;
        for (int i = 0; i < 300; i++) begin
            re  = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            sel = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(2, 3)) : SW'($urandom_range(0, 1));
            a   = AW'($urandom_range(0, 15));
            src = $urandom();
            wv  = (int'(sel) < NS) ? src[int'(sel)*DW +: DW] : '0;
            exp_v = re;
            if (re) m_out = (we && int'(sel) < NS) ? wv : mdl[a];
            if (we && int'(sel) < NS) mdl[a] = wv;
            if (we && int'(sel) >= NS) m_err = 1'b1;
            drive(re, we, sel, a, src, 0);
            total++; if (bus.data_valid !== exp_v || bus.data_out !== m_out || bus.sel_err !== m_err)
                begin bad++; $display("FAIL rand[%0d]: got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                      i, bus.data_valid, bus.data_out, bus.sel_err, exp_v, m_out, m_err); end
        end
        idle();
    endtask

    task automatic test_clear();
        int n;
        int vseen;
        drive(0, 1, 2'd0, 10'd1023, {16'h0000, 16'hBEEF}, 0);
        drive(1, 0, '0, 10'd1023, '0, 0);
        total++; if (bus.data_out !== 16'hBEEF) begin bad++; $display("FAIL clr_wr: got %h want beef", bus.data_out); end
        drive(0, 1, 2'd3, 10'd7, '0, 0);
        drive(1, 1, 2'd1, 10'd1023, {16'h1111, 16'h2222}, 1);
        total++; if (bus.ready !== 1'b0 || bus.data_valid !== 1'b0 || bus.sel_err !== 1'b0 || bus.data_out !== 16'hBEEF)
            begin bad++; $display("FAIL clr_enter: got r=%b v=%b e=%b d=%h want r=0 v=0 e=0 d=beef",
                                  bus.ready, bus.data_valid, bus.sel_err, bus.data_out); end
        n = 0; vseen = 0;
        do begin
            if (n == 10) begin
                bus.clear = 1'b1; bus.read_en = 1'b1; bus.write_en = 1'b1;
                bus.address = 10'd1023; bus.data_src = 32'h3333_3333;
            end else idle();
            @(posedge clk); #1; n++;
            if (bus.data_valid === 1'b1) vseen++;
        end while (bus.ready !== 1'b1 && n < 2000);
        idle();
        total++; if (n != DEPTH) begin bad++; $display("FAIL clr_len: got %0d want %0d", n, DEPTH); end
        total++; if (vseen != 0) begin bad++; $display("FAIL clr_ignored: got %0d valids want 0", vseen); end
        drive(1, 0, '0, 10'd1023, '0, 0);
        total++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'h0000)
            begin bad++; $display("FAIL clr_zero: got v=%b d=%h want v=1 d=0000", bus.data_valid, bus.data_out); end
        drive(1, 0, '0, 10'd5, '0, 0);
        total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL clr_zero5: got %h want 0000", bus.data_out); end
        model_zero();
    endtask

    task automatic test_rst_mid();
        int n;
        drive(0, 1, 2'd0, 10'd2, {16'h0000, 16'h00AB}, 0);
        drive(1, 0, '0, 10'd2, '0, 0);
        drive(0, 1, 2'd2, 10'd2, '0, 0);
        total++; if (bus.data_out !== 16'h00AB || bus.sel_err !== 1'b1)
            begin bad++; $display("FAIL rm_pre: got d=%h e=%b want d=00ab e=1", bus.data_out, bus.sel_err); end
        bus.read_en = 1'b1; bus.write_en = 1'b0; bus.address = 10'd2;
        #2; rst = 1'b0; #1;
        total++; if (bus.data_out !== '0 || bus.data_valid !== 1'b0 || bus.ready !== 1'b0 || bus.sel_err !== 1'b0)
            begin bad++; $display("FAIL rm_async: got d=%h v=%b r=%b e=%b want all 0",
                                  bus.data_out, bus.data_valid, bus.ready, bus.sel_err); end
        idle();
        @(posedge clk); #1;
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rm_drop: got %b want 0", bus.data_valid); end
        rst = 1'b1;
        for (int i = 0; i < 500; i++) begin @(posedge clk); #1; end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rm_sweep500: got %b want 0", bus.ready); end
        #2; rst = 1'b0; #1;
        total++; if (bus.ready !== 1'b0 || bus.data_out !== '0 || bus.data_valid !== 1'b0)
            begin bad++; $display("FAIL rm_sweep_rst: got r=%b d=%h v=%b want 0", bus.ready, bus.data_out, bus.data_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (bus.ready !== 1'b1 && n < 2000);
        total++; if (n != DEPTH) begin bad++; $display("FAIL rm_len: got %0d want %0d", n, DEPTH); end
        drive(1, 0, '0, 10'd2, '0, 0);
        total++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'h0000)
            begin bad++; $display("FAIL rm_zero: got v=%b d=%h want v=1 d=0000", bus.data_valid, bus.data_out); end
        idle();
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_write_read();
        test_rw_same();
        test_sel_err();
        test_random();
        test_clear();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
